// File: rtl/nibble_packer_pkg.sv
// Shared definitions for the nibble packer and the downstream concatenation
// stage: FSM state encoding and the nibble-count / counter-width derivation.
package nibble_packer_pkg;

  // FILL collects nibbles, HOLD presents a finished word downstream.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Number of 4-bit slots in a word of the given width.
  function automatic int nibbles_of(input int size);
    return size / 4;
  endfunction

  // Counter width able to hold 0..nibbles_of(size) inclusive.
  function automatic int cnt_w_of(input int size);
    return $clog2(size / 4) + 1;
  endfunction

endpackage

// File: rtl/nibble_packer_pad_merge.sv
// Combinational padding mux: left-justifies the low `count` nibbles of acc
// and fills the remaining low slots with PAD_NIBBLE. Built slot by slot so no
// zero-width replication can arise for any count.
module nibble_pad_merge
  import nibble_packer_pkg::*;
#(
  parameter int          SIZE       = 16,
  parameter logic [3:0]  PAD_NIBBLE = 4'b1111,
  localparam int         NIBBLES    = nibbles_of(SIZE),
  localparam int         CNT_W      = cnt_w_of(SIZE)
) (
  input  logic [SIZE-1:0]  acc,
  input  logic [CNT_W-1:0] count,
  output logic [SIZE-1:0]  word
);

  // Slot s counts from the MSB; real nibble s sits at LSB position count-1-s.
  always_comb begin
    word = acc;
    for (int s = 0; s < NIBBLES; s++) begin
      if (s < int'(count)) begin
        word[SIZE-1-4*s -: 4] = acc[4*(int'(count)-1-s) +: 4];
      end else begin
        word[SIZE-1-4*s -: 4] = PAD_NIBBLE;
      end
    end
  end

endmodule

// File: rtl/nibble_packer.sv
// Nibble packer: collects 4-bit nibbles into a SIZE-bit word, first nibble in
// the MSBs. A flush closes a partial word, padding unfilled slots.
//
// Handshake: a transfer happens on a rising edge where valid && ready. Input
// side: in_ready is high only in FILL. Output side: out_valid is high only in
// HOLD; out_word/out_count stay stable until out_ready is seen, and the FSM
// returns to FILL on the following cycle.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int          SIZE       = 16,
  parameter logic [3:0]  PAD_NIBBLE = 4'b1111,
  localparam int         NIBBLES    = nibbles_of(SIZE),
  localparam int         CNT_W      = cnt_w_of(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_nibble,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_word,
  output logic [CNT_W-1:0] out_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  acc_q, acc_d;
  logic [SIZE-1:0]  word_q, word_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept;
  logic [SIZE-1:0]  acc_new;
  logic [CNT_W-1:0] cnt_new;
  logic [SIZE-1:0]  padded;

  assign accept  = in_valid && (state_q == FILL);
  // Accumulator and count as they stand once this cycle's nibble is included,
  // so a flush arriving with a nibble pads after that nibble.
  assign acc_new = accept ? {acc_q[SIZE-5:0], in_nibble} : acc_q;
  assign cnt_new = accept ? cnt_q + CNT_W'(1) : cnt_q;

  nibble_pad_merge #(
    .SIZE       (SIZE),
    .PAD_NIBBLE (PAD_NIBBLE)
  ) u_pad (
    .acc   (acc_new),
    .count (cnt_new),
    .word  (padded)
  );

  // Next-state and output-register logic for the FILL/HOLD FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    word_d  = word_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        acc_d = acc_new;
        cnt_d = cnt_new;
        if (accept && (cnt_new == CNT_W'(NIBBLES))) begin
          // A full word never takes the padding path.
          state_d = HOLD;
          word_d  = acc_new;
          count_d = cnt_new;
        end else if (flush && (cnt_new != '0)) begin
          state_d = HOLD;
          word_d  = padded;
          count_d = cnt_new;
        end
      end
      HOLD: begin
        // Flush and in_valid are ignored here; nothing is remembered.
        if (out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          acc_d   = '0;
          word_d  = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
        acc_d   = '0;
        word_d  = '0;
        count_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_word  = word_q;
  assign out_count = count_q;

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Upstream stage for the concatenation/replication datapath: collects a stream of 4-bit nibbles and concatenates them into one SIZE-bit word.
- Partial words can be flushed out early. Unfilled nibble positions are padded with a replicated pad value.
- Valid/ready handshake on both sides. Single clock domain.

Parameters:
- SIZE, 16, output word width in bits; must be a multiple of 4 and at least 8.
- PAD_NIBBLE, 4'b1111, value replicated into unfilled nibble slots on flush.
- Derived localparam NIBBLES = SIZE/4.
- Derived localparam CNT_W = clog2(NIBBLES)+1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_nibble is valid this cycle.
- in_ready  output  1  packer can accept a nibble.
- in_nibble  input  4  nibble data.
- flush  input  1  close the current partial word.
- out_valid  output  1  out_word/out_count hold a complete or flushed word.
- out_ready  input  1  downstream accepts the word.
- out_word  output  SIZE  packed word; first-accepted nibble in bits [SIZE-1:SIZE-4].
- out_count  output  CNT_W  number of real (non-pad) nibbles in out_word, range 1..NIBBLES.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n low at a clk edge) overrides everything:
  - state=FILL, fill count=0, accumulator=0.
  - out_valid=0, out_word=0, out_count=0, in_ready=1.
- Reset mid-word or mid-hold discards the partial or held word; nothing is emitted.
- Two states: FILL and HOLD.
  - in_ready = (state==FILL).
  - out_valid = (state==HOLD).
- Nibble accept = in_valid && in_ready.
  - On accept, the accumulator shifts left by 4 with in_nibble entering the LSBs, i.e. acc <= {acc[SIZE-5:0], in_nibble}. The count increments.
- FILL to HOLD on the accept that makes count==NIBBLES.
  - out_word = accumulator, out_count = NIBBLES.
  - Latency: out_valid is high the cycle after the last nibble is accepted.
- Flush in FILL, no accept, count>0:
  - Output is the existing nibbles left-justified, with the (NIBBLES-count) low slots set to PAD_NIBBLE.
  - out_count = count. Go to HOLD.
- Flush together with an accept in the same cycle:
  - The nibble is included first, then padding is applied.
  - out_count = count+1. Go to HOLD.
  - If that accept also fills the word, this is a normal full word with no padding.
- Flush in FILL with count==0 and no accept: ignored, nothing emitted.
- Flush in HOLD: ignored, not remembered.
- HOLD:
  - out_word and out_count stay stable while out_ready is low.
  - When out_ready is high: go to FILL, count=0, accumulator=0, out_valid=0 on the next cycle.
  - No simultaneous accept in HOLD. Peak throughput is one word per NIBBLES+1 cycles.
- in_nibble is ignored when in_valid is low. in_valid asserted in HOLD is not consumed.
- Width rules:
  - The pad field is built by replication: {(NIBBLES-k){PAD_NIBBLE}}.
  - Width arithmetic must never produce a zero-width replication. The k==NIBBLES case takes the unpadded path.

Decomposition:
- Shared header holds:
  - state encodings FILL=1'b0, HOLD=1'b1;
  - the NIBBLES/CNT_W derivation macro, reused by the downstream concatenation stage.
- No sub-module required. The padding mux may optionally be split out as nibble_pad_merge (combinational: acc, count -> padded word).
- Target roughly 150 lines of RTL.

Test Plan:
- Full word (SIZE=16): nibbles 5, C, A, 3 on consecutive cycles, out_ready=1 -> one cycle later out_valid=1, out_word=16'h5CA3, out_count=4; in_ready=0 during HOLD.
- Partial flush: accept 5, then flush alone next cycle -> out_word=16'h5FFF, out_count=1; count back to 0 after the handshake.
- Flush with data: accept 5, then C together with flush -> out_word=16'h5CFF, out_count=2; flush at empty afterwards emits nothing.
- Backpressure: complete 16'h1234, hold out_ready=0 for 3 cycles while driving in_valid=1 and flush=1 -> out_word stays 16'h1234, in_ready=0, no nibble consumed, no extra word; out_ready=1 releases it.
- Reset mid-operation: accept 7, 8, then rst_n=0 for one cycle -> out_valid=0, out_count=0; next nibbles 9, A, B, C yield 16'h9ABC with no trace of 7 or 8.
- Parameter variant SIZE=8, PAD_NIBBLE=4'b0000: nibbles 0101, 1100 -> out_word=8'b01011100; nibble 0101 plus flush -> 8'b01010000, out_count=1.
